finish_overlay: RTL and testbench

Generates read addresses for the game-over banner ROM (`finish`, 320x67, 12-bit RGB, one-cycle registered read) and composites the returned pixels over the live game picture. Sits between the VGA timing/background renderer and the VGA output register. Runs a per-frame blink-then-solid sequence once a winner is declared. Latches the winner at frame boundaries so the banner never tears.

---
 rtl/game_pkg.sv | 21 ++
 rtl/finish_overlay_if.sv | 26 ++
 rtl/pipe_delay.sv | 25 ++
 rtl/finish_overlay.sv | 141 ++++++++++++++
 tb/tb_finish_overlay.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared screen/banner constants, overlay FSM encoding and pixel type
// for the game-over banner path.
package game_pkg;

   localparam int unsigned SCREEN_W     = 640;
   localparam int unsigned SCREEN_H     = 480;
   localparam int unsigned BANNER_X_DEF = 160;
   localparam int unsigned BANNER_Y_DEF = 206;
   localparam int unsigned BANNER_W_DEF = 320;
   localparam int unsigned BANNER_H_DEF = 67;
   localparam int unsigned ROM_AW       = 15;

   typedef logic [11:0] rgb_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLINK = 2'd1,
      ST_SOLID = 2'd2
   } ovl_state_t;

endpackage

// File: rtl/finish_overlay_if.sv
// Video-in, banner-ROM and composited-out signals of the finish overlay.
interface finish_overlay_if;
   import game_pkg::*;

   logic [9:0]        hcount;
   logic [9:0]        vcount;
   logic              video_on;
   rgb_t              bg_pixel;
   logic [1:0]        finish;
   logic [ROM_AW-1:0] rom_addr;
   logic [1:0]        rom_sel;
   rgb_t              rom_pixel;
   rgb_t              rgb_out;
   logic              banner_active;

   modport slave (
      input  hcount, vcount, video_on, bg_pixel, finish, rom_pixel,
      output rom_addr, rom_sel, rgb_out, banner_active
   );

   modport master (
      output hcount, vcount, video_on, bg_pixel, finish, rom_pixel,
      input  rom_addr, rom_sel, rgb_out, banner_active
   );

endinterface

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with asynchronous active-low clear.
module pipe_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/finish_overlay.sv
// Game-over banner overlay: ROM address generation, frame-latched
// blink/solid sequencing and 3-cycle aligned compositing over the game layer.
module finish_overlay
   import game_pkg::*;
#(
   parameter int unsigned BANNER_X     = BANNER_X_DEF,
   parameter int unsigned BANNER_Y     = BANNER_Y_DEF,
   parameter int unsigned BANNER_W     = BANNER_W_DEF,
   parameter int unsigned BANNER_H     = BANNER_H_DEF,
   parameter rgb_t        KEY_COLOR    = 12'h000,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned BLINK_PHASES = 6
) (
   input logic             clk,
   input logic             rst_l,
   finish_overlay_if.slave ovl
);

   localparam int unsigned CNT_W = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned PH_W  = $clog2(BLINK_PHASES + 1);
   localparam logic [10:0] X_LO  = 11'(BANNER_X);
   localparam logic [10:0] X_HI  = 11'(BANNER_X + BANNER_W);
   localparam logic [10:0] Y_LO  = 11'(BANNER_Y);
   localparam logic [10:0] Y_HI  = 11'(BANNER_Y + BANNER_H);

   ovl_state_t        state_q, state_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              show_q, show_next, show_now;
   logic [1:0]        fin_q;
   logic              synced;
   logic [ROM_AW-1:0] addr_cnt, addr_base;
   logic              frame_start, in_win;
   logic [10:0]       hc, vc;
   logic [14:0]       dly_out;
   logic              show_dd, win_dd, von_dd;
   rgb_t              bg_dd;

   assign hc          = {1'b0, ovl.hcount};
   assign vc          = {1'b0, ovl.vcount};
   assign frame_start = (ovl.hcount == '0) && (ovl.vcount == '0);
   // Counting stays frozen after a mid-frame reset until the raster restarts.
   assign in_win = (synced || frame_start) && ovl.video_on &&
                   (hc >= X_LO) && (hc < X_HI) && (vc >= Y_LO) && (vc < Y_HI);

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (frame_start) begin
         if (ovl.finish == 2'b00) begin
            state_d     = ST_IDLE;
            frame_cnt_d = '0;
            phase_d     = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_d     = ST_BLINK;
                  frame_cnt_d = '0;
                  phase_d     = '0;
               end
               ST_BLINK: begin
                  if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                     frame_cnt_d = '0;
                     phase_d     = phase_q + 1'b1;
                     if (phase_d == PH_W'(BLINK_PHASES)) state_d = ST_SOLID;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 1'b1;
                  end
               end
               ST_SOLID: state_d = ST_SOLID;
               default:  state_d = ST_IDLE;
            endcase
         end
      end
      show_next = (state_d == ST_SOLID) || ((state_d == ST_BLINK) && !phase_d[0]);
      show_now  = frame_start ? show_next : show_q;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         phase_q     <= '0;
         show_q      <= 1'b0;
         fin_q       <= '0;
         synced      <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
         show_q      <= show_now;
         if (frame_start) begin
            fin_q  <= ovl.finish;
            synced <= 1'b1;
         end
      end
   end

   assign addr_base = frame_start ? '0 : addr_cnt;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         addr_cnt     <= '0;
         ovl.rom_addr <= '0;
      end else if (in_win) begin
         ovl.rom_addr <= addr_base;
         addr_cnt     <= addr_base + 1'b1;
      end else begin
         addr_cnt     <= addr_base;
      end
   end

   pipe_delay #(.WIDTH(15), .DEPTH(2)) u_align (
      .clk   (clk),
      .rst_l (rst_l),
      .din   ({show_now, in_win, ovl.video_on, ovl.bg_pixel}),
      .dout  (dly_out)
   );

   assign show_dd = dly_out[14];
   assign win_dd  = dly_out[13];
   assign von_dd  = dly_out[12];
   assign bg_dd   = dly_out[11:0];

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         ovl.rgb_out <= '0;
      end else if (!von_dd) begin
         ovl.rgb_out <= '0;
      end else if (show_dd && win_dd && (ovl.rom_pixel != KEY_COLOR)) begin
         ovl.rgb_out <= ovl.rom_pixel;
      end else begin
         ovl.rgb_out <= bg_dd;
      end
   end

   assign ovl.rom_sel       = fin_q;
   assign ovl.banner_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_finish_overlay.sv
// Randomised raster bench for finish_overlay with a frame-level reference
// model of the banner sequence and a synchronous banner-ROM stand-in.
module tb_finish_overlay;

   localparam int BX = 160;
   localparam int BY = 206;
   localparam int BW = 320;
   localparam int BH = 67;
   localparam int BF = 2;
   localparam int BP = 4;

   logic clk = 1'b0;
   logic rst_l;

   finish_overlay_if ifc ();

   finish_overlay #(
      .BLINK_FRAMES (BF),
      .BLINK_PHASES (BP)
   ) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .ovl   (ifc)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_fn(input logic [14:0] a, input logic [1:0] s);
      int unsigned m;
      m = a % 5;
      if (m == 0) return 12'h000;
      if (m == 1) return 12'h0F0;
      return 12'(a * 37 + s * 911) | 12'h001;
   endfunction

   always @(posedge clk) ifc.rom_pixel <= rom_fn(ifc.rom_addr, ifc.rom_sel);

   int          n_checks = 0;
   int          n_errors = 0;
   bit          m_active, m_synced, full_frame;
   int          m_fs, m_cnt;
   logic [1:0]  m_sel, fin;
   logic [11:0] pend [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] rand_bg();
      if ($urandom_range(3) == 0) return 12'hF00;
      return 12'($urandom);
   endfunction

   task automatic step(input int h, input int v, input bit von, input logic [11:0] bg);
      bit          fs, win, show;
      int          a;
      logic [11:0] rv, exp_rgb;
      ifc.hcount   = 10'(h);
      ifc.vcount   = 10'(v);
      ifc.video_on = von;
      ifc.bg_pixel = bg;
      ifc.finish   = fin;
      fs = (h == 0) && (v == 0);
      if (fs) begin
         m_synced = 1;
         m_cnt    = 0;
         m_sel    = fin;
         if (fin == 2'b00) m_active = 0;
         else if (!m_active) begin m_active = 1; m_fs = 0; end
         else m_fs++;
      end
      show = m_active && ((m_fs >= BF * BP) || (((m_fs / BF) % 2) == 0));
      win  = m_synced && von && (h >= BX) && (h < BX + BW) && (v >= BY) && (v < BY + BH);
      a = m_cnt;
      if (win) m_cnt++;
      rv = rom_fn(15'(a), m_sel);
      if (!von) exp_rgb = 12'h000;
      else if (show && win && rv != 12'h000) exp_rgb = rv;
      else exp_rgb = bg;
      pend.push_back(exp_rgb);
      @(posedge clk);
      #1;
      if (win) check_val("rom_addr", 32'(ifc.rom_addr), a);
      if (!m_synced) check_val("addr_unsynced", 32'(ifc.rom_addr), 0);
      if (full_frame && h == BX && v == BY) check_val("addr_first", 32'(ifc.rom_addr), 0);
      if (full_frame && h == BX + BW - 1 && v == BY + BH - 1)
         check_val("addr_last", 32'(ifc.rom_addr), 21439);
      check_val("rom_sel", 32'(ifc.rom_sel), 32'(m_sel));
      check_val("banner_active", 32'(ifc.banner_active), 32'(m_active));
      if (pend.size() == 3) begin
         check_val("rgb_out", 32'(ifc.rgb_out), 32'(pend[0]));
         void'(pend.pop_front());
      end
   endtask

   task automatic row(input int v, input int c0, input int c1, input bit drop);
      for (int c = c0; c <= c1; c++)
         step(c, v, (v < 480) && (c < 640) && !(drop && $urandom_range(31) == 0), rand_bg());
   endtask

   task automatic frame_head();
      step(0, 0, 1, rand_bg());
      repeat (5) step($urandom_range(639), $urandom_range(BY - 2, 1), 1, rand_bg());
   endtask

   task automatic sparse_frame(input logic [1:0] fin_mid);
      frame_head();
      row(BY - 1, BX - 3, BX + BW + 2, 0);
      row(BY, BX - 3, BX + BW + 2, 1);
      fin = fin_mid;
      row(BY + 1 + $urandom_range(BH - 3), BX - 3, BX + BW + 2, 1);
      row(BY + BH - 1, BX - 3, BX + BW + 2, 1);
      row(490, 0, 20, 0);
   endtask

   task automatic full_win_frame();
      frame_head();
      full_frame = 1;
      for (int v = BY - 1; v <= BY + BH; v++) row(v, BX - 2, BX + BW + 1, 0);
      full_frame = 0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_rgb"}, 32'(ifc.rgb_out), 0);
      check_val({tag, "_addr"}, 32'(ifc.rom_addr), 0);
      check_val({tag, "_sel"}, 32'(ifc.rom_sel), 0);
      check_val({tag, "_active"}, 32'(ifc.banner_active), 0);
   endtask

   task automatic do_reset(input int cycles);
      rst_l = 1'b0;
      #1;
      check_zero_outputs("rst_now");
      repeat (cycles) begin
         ifc.hcount   = 10'($urandom);
         ifc.vcount   = 10'($urandom);
         ifc.video_on = 1'($urandom);
         ifc.bg_pixel = rand_bg();
         ifc.finish   = 2'($urandom);
         @(posedge clk);
         #1;
      end
      check_zero_outputs("rst_hold");
      pend.delete();
      m_active = 0;
      m_synced = 0;
      m_sel    = 2'b00;
      m_cnt    = 0;
      m_fs     = 0;
      rst_l    = 1'b1;
   endtask

   initial begin
      rst_l      = 1'b1;
      fin        = 2'b00;
      full_frame = 0;
      ifc.hcount = '0; ifc.vcount = '0; ifc.video_on = 1'b0;
      ifc.bg_pixel = '0; ifc.finish = '0;
      #2;
      do_reset(4);

      sparse_frame(2'b00);
      sparse_frame(2'b01);
      full_win_frame();
      repeat (9) sparse_frame(2'b01);
      sparse_frame(2'b10);
      sparse_frame(2'b10);

      // solid banner, P2: reset lands mid-window
      frame_head();
      row(BY, BX - 3, BX + BW + 2, 0);
      row(230, BX - 3, 300, 0);
      do_reset(3);
      row(230, 301, BX + BW + 2, 0);
      row(231, BX - 3, BX + BW + 2, 0);

      sparse_frame(2'b10);
      sparse_frame(2'b00);
      sparse_frame(2'b00);
      repeat (4) step(5, 1, 1, rand_bg());

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
